// File: rtl/ib_ob_pkg.sv
// ---------------------------------------------------------------------------
// ib_ob_pkg
// Shared definitions for the inbound write path.
//   wr_state_e   : write-slave FSM states (IDLE -> DATA -> RESP -> IDLE)
//   BRESP_*      : AXI B-channel response codes used by the slave
//   BURST_INCR   : the only burst type the slave treats as legal
// ---------------------------------------------------------------------------
package ib_ob_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR   = 2'b01;

endpackage

// File: rtl/ib_wr_addr_gen.sv
// ---------------------------------------------------------------------------
// ib_wr_addr_gen
// RAM word pointer and beat counter for one write burst.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i         : start of burst; loads start_ptr_i / len_i, clears count
//   start_ptr_i    : first RAM word address of the burst
//   len_i          : AXI awlen (beats - 1)
//   inc_i          : one beat accepted; advance pointer and count
//   ptr_o          : RAM word address for the current beat
//   beats_o        : number of beats accepted so far (0..256)
//   last_o         : the beat currently offered is the final one (index == len)
// ---------------------------------------------------------------------------
module ib_wr_addr_gen #(
  parameter int RAM_AW = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [RAM_AW-1:0] start_ptr_i,
  input  logic [7:0]        len_i,
  input  logic              inc_i,
  output logic [RAM_AW-1:0] ptr_o,
  output logic [8:0]        beats_o,
  output logic              last_o
);

  logic [RAM_AW-1:0] ptr_q, ptr_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [7:0]        len_q, len_d;

  // The pointer is exactly RAM_AW bits wide, so the increment wraps modulo
  // the RAM depth for free; a wrap is not an error condition.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    len_d = len_q;
    if (load_i) begin
      ptr_d = start_ptr_i;
      cnt_d = 9'd0;
      len_d = len_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
      cnt_d = cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  assign ptr_o   = ptr_q;
  assign beats_o = cnt_q;
  // cnt_q is the zero-based index of the beat being offered right now.
  assign last_o  = (cnt_q == {1'b0, len_q});

endmodule

// File: rtl/ib_axi_wr_slave.sv
// ---------------------------------------------------------------------------
// ib_axi_wr_slave
// AXI-MM write slave in front of the inbound RAM buffer. Accepts one INCR
// burst at a time, writes each beat into the RAM (one-cycle registered
// write port), returns B, then pulses IbWrDone to the RAM controller.
//
// Build option: define IB_WR_STRB_EN to forward wstrb to ram_wstrb;
// otherwise ram_wstrb is all ones and wstrb is ignored.
//
// Ports
//   clk, rst                   : clock, synchronous active-high reset
//   aw*  (awvalid/awready/awid/awaddr/awlen/awburst) : write address channel
//   w*   (wvalid/wready/wdata/wstrb/wlast)           : write data channel
//   b*   (bvalid/bready/bid/bresp)                   : write response channel
//   ram_we/ram_addr/ram_wdata/ram_wstrb : registered RAM write port
//   IbWrDone   : 1-cycle pulse after the B handshake, burst is in RAM
//   IbWrBeats  : beats accepted in the last completed burst (held)
//   IbBufBusy  : buffer owned downstream; blocks a new AW only
//   dbg_state_o: current FSM state (wr_state_e encoding)
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both high; valid never waits for ready.
// ---------------------------------------------------------------------------
module ib_axi_wr_slave
  import ib_ob_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int RAM_AW = 9,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wstrb,
  output logic                IbWrDone,
  output logic [8:0]          IbWrBeats,
  input  logic                IbBufBusy,
  output logic [1:0]          dbg_state_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  wr_state_e           state_q;
  logic                err_q;
  logic                bvalid_q;
  logic [ID_W-1:0]     bid_q;
  logic [1:0]          bresp_q;
  logic                ram_we_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic [STRB_W-1:0]   ram_wstrb_q;
  logic                done_q;
  logic [8:0]          beats_q;

  logic                aw_hs;
  logic                w_hs;
  logic [RAM_AW-1:0]   gen_ptr;
  logic [8:0]          gen_beats;
  logic                gen_last;
  logic [STRB_W-1:0]   strb_next;

  // awready is combinational so a drop of IbBufBusy is seen in the same
  // cycle; it is also held low while reset is asserted.
  assign awready = (state_q == IDLE) && !IbBufBusy && !rst;
  assign wready  = (state_q == DATA);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

`ifdef IB_WR_STRB_EN
  assign strb_next = wstrb;
`else
  assign strb_next = '1;
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;
`endif

  // Address bits outside the RAM word window do not select anything.
  logic unused_addr;
  assign unused_addr = ^{awaddr[31:RAM_AW+OFF_W], awaddr[OFF_W-1:0]};

  ib_wr_addr_gen #(
    .RAM_AW (RAM_AW)
  ) u_addr_gen (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (aw_hs),
    .start_ptr_i (awaddr[RAM_AW+OFF_W-1:OFF_W]),
    .len_i       (awlen),
    .inc_i       (w_hs),
    .ptr_o       (gen_ptr),
    .beats_o     (gen_beats),
    .last_o      (gen_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= BRESP_OKAY;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wstrb_q <= '0;
      done_q      <= 1'b0;
      beats_q     <= '0;
    end else begin
      ram_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (aw_hs) begin
            bid_q   <= awid;
            err_q   <= (awburst != BURST_INCR);
            state_q <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            // Data is committed even when the burst ends in SLVERR.
            ram_we_q    <= 1'b1;
            ram_addr_q  <= gen_ptr;
            ram_wdata_q <= wdata;
            ram_wstrb_q <= strb_next;
            // bvalid rises together with the final ram_we, so the B
            // response (and IbWrDone after it) never precedes the write.
            if (gen_last) begin
              err_q    <= err_q || !wlast;
              bresp_q  <= (err_q || !wlast) ? BRESP_SLVERR : BRESP_OKAY;
              bvalid_q <= 1'b1;
              state_q  <= RESP;
            end else if (wlast) begin
              // Early wlast truncates the burst; remaining beats are refused.
              err_q    <= 1'b1;
              bresp_q  <= BRESP_SLVERR;
              bvalid_q <= 1'b1;
              state_q  <= RESP;
            end
          end
        end
        RESP: begin
          if (bready) begin
            bvalid_q <= 1'b0;
            done_q   <= 1'b1;
            beats_q  <= gen_beats;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bvalid      = bvalid_q;
  assign bid         = bid_q;
  assign bresp       = bresp_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_wstrb   = ram_wstrb_q;
  assign IbWrDone    = done_q;
  assign IbWrBeats   = beats_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ib_axi_wr_slave.sv
// ---------------------------------------------------------------------------
// tb_ib_axi_wr_slave
// Randomized scoreboard bench for ib_axi_wr_slave (DATA_W=64, RAM_AW=4).
// Drivers push the expected RAM writes and B responses when a burst is
// issued; a negedge monitor pops and compares whenever the DUT shows them.
// ---------------------------------------------------------------------------
module tb_ib_axi_wr_slave;

  localparam int DATA_W = 64;
  localparam int RAM_AW = 4;
  localparam int ID_W   = 4;
  localparam int EW_W   = 4 + 8 + 64;   // {addr, strb, data}
  localparam int EB_W   = 4 + 2 + 9;    // {id, resp, beats}

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                awvalid = 1'b0;
  logic                awready;
  logic [ID_W-1:0]     awid = '0;
  logic [31:0]         awaddr = '0;
  logic [7:0]          awlen = '0;
  logic [1:0]          awburst = 2'b01;
  logic                wvalid = 1'b0;
  logic                wready;
  logic [DATA_W-1:0]   wdata = '0;
  logic [DATA_W/8-1:0] wstrb = '0;
  logic                wlast = 1'b0;
  logic                bvalid;
  logic                bready = 1'b0;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                ram_we;
  logic [RAM_AW-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W/8-1:0] ram_wstrb;
  logic                IbWrDone;
  logic [8:0]          IbWrBeats;
  logic                IbBufBusy = 1'b0;
  logic [1:0]          dbg_state;

  ib_axi_wr_slave #(
    .DATA_W (DATA_W),
    .RAM_AW (RAM_AW),
    .ID_W   (ID_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .awvalid     (awvalid),
    .awready     (awready),
    .awid        (awid),
    .awaddr      (awaddr),
    .awlen       (awlen),
    .awburst     (awburst),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wlast       (wlast),
    .bvalid      (bvalid),
    .bready      (bready),
    .bid         (bid),
    .bresp       (bresp),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_wstrb   (ram_wstrb),
    .IbWrDone    (IbWrDone),
    .IbWrBeats   (IbWrBeats),
    .IbBufBusy   (IbBufBusy),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW_W-1:0] exp_w_q[$];
  logic [EB_W-1:0] exp_b_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  bit         pend_done = 0;
  logic [8:0] pend_beats = '0;
  bit         prev_bvalid = 0;

  always @(negedge clk) begin
    logic [EW_W-1:0] ew;
    logic [EB_W-1:0] eb;
    if (rst) begin
      pend_done   = 0;
      prev_bvalid = 0;
    end else begin
      if (IbWrDone || pend_done) begin
        chk("ibwrdone_pulse", 128'(IbWrDone), 128'(pend_done));
        if (IbWrDone && pend_done) chk("ibwrbeats", 128'(IbWrBeats), 128'(pend_beats));
      end
      pend_done = 0;
      if (ram_we) begin
        if (exp_w_q.size() == 0) begin
          chk("unexpected_ram_write", 128'(1), 128'(0));
        end else begin
          ew = exp_w_q.pop_front();
          chk("ram_addr",  128'(ram_addr),  128'(ew[75:72]));
          chk("ram_wstrb", 128'(ram_wstrb), 128'(ew[71:64]));
          chk("ram_wdata", 128'(ram_wdata), 128'(ew[63:0]));
        end
      end
      if (bvalid && !prev_bvalid) chk("bvalid_with_last_we", 128'(ram_we), 128'(1));
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) begin
          chk("unexpected_b", 128'(1), 128'(0));
        end else begin
          eb = exp_b_q.pop_front();
          chk("bid",   128'(bid),   128'(eb[14:11]));
          chk("bresp", 128'(bresp), 128'(eb[10:9]));
          pend_done  = 1;
          pend_beats = eb[8:0];
        end
      end
      prev_bvalid = bvalid;
    end
  end

  // ---------------- drivers ----------------
  // All drivers start and end at posedge+1.
  task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input int busy_pre);
    bit hs;
    int budget;
    awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
    if (busy_pre > 0) begin
      // Busy buffer blocks AW; an early W must not be taken either.
      IbBufBusy = 1'b1; wvalid = 1'b1; wlast = 1'b1; wdata = '1;
      repeat (busy_pre) begin
        #1;
        chk("awready_busy", 128'(awready), 128'(0));
        chk("wready_idle",  128'(wready),  128'(0));
        @(posedge clk); #1;
      end
      IbBufBusy = 1'b0; wvalid = 1'b0; wlast = 1'b0;
      #1;
      chk("awready_unbusy", 128'(awready), 128'(1));
    end
    hs = 0; budget = 200;
    while (!hs && budget > 0) begin
      #1 hs = awready;
      @(posedge clk); #1;
      budget--;
    end
    if (!hs) chk("aw_timeout", 128'(0), 128'(1));
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input int word, input bit last);
    bit hs;
    int budget;
    logic [63:0] d;
    logic [7:0]  s, es;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    d = {$urandom, $urandom};
    s = 8'($urandom);
`ifdef IB_WR_STRB_EN
    es = s;
`else
    es = 8'hff;
`endif
    exp_w_q.push_back({4'(word % 16), es, d});
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
    IbBufBusy = 1'($urandom_range(0, 1));
    hs = 0; budget = 200;
    while (!hs && budget > 0) begin
      #1 hs = wready;
      @(posedge clk); #1;
      budget--;
    end
    if (!hs) chk("w_timeout", 128'(0), 128'(1));
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_phase();
    int budget;
    budget = 50;
    while (!bvalid && budget > 0) begin @(posedge clk); #1; budget--; end
    if (!bvalid) begin
      chk("b_timeout", 128'(0), 128'(1));
    end else begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
    end
  endtask

  // Reference model: beats sent = up to and including the first wlast, capped
  // at len+1; error if burst is not INCR or wlast is not on beat len.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int wlast_at, input int busy_pre);
    int  nsend, start_w;
    bit  err;
    nsend   = (wlast_at < len) ? wlast_at + 1 : len + 1;
    err     = (burst != 2'b01) || (wlast_at != len);
    start_w = int'(addr >> 3) % 16;
    exp_b_q.push_back({id, err ? 2'b10 : 2'b00, 9'(nsend)});
    aw_phase(id, addr, len, burst, busy_pre);
    for (int i = 0; i < nsend; i++) w_beat(start_w + i, i == wlast_at);
    IbBufBusy = 1'b0;
    b_phase();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"},   128'(awready),   128'(0));
    chk({tag, "_wready"},    128'(wready),    128'(0));
    chk({tag, "_bvalid"},    128'(bvalid),    128'(0));
    chk({tag, "_ram_we"},    128'(ram_we),    128'(0));
    chk({tag, "_ibwrdone"},  128'(IbWrDone),  128'(0));
    chk({tag, "_bid"},       128'(bid),       128'(0));
    chk({tag, "_bresp"},     128'(bresp),     128'(0));
    chk({tag, "_ram_addr"},  128'(ram_addr),  128'(0));
    chk({tag, "_ram_wdata"}, 128'(ram_wdata), 128'(0));
    chk({tag, "_ram_wstrb"}, 128'(ram_wstrb), 128'(0));
    chk({tag, "_ibwrbeats"}, 128'(IbWrBeats), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int len, wl;
    logic [1:0] bt;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_burst(4'd1, 32'h40, 3, 2'b01, 3, 0);     // words 8..11, OKAY
    run_burst(4'd2, 32'h00, 1, 2'b01, 1, 3);     // busy gating then accept
    run_burst(4'd3, 32'h18, 3, 2'b01, 1, 0);     // early wlast -> 2 beats, SLVERR
    run_burst(4'd4, 32'h70, 3, 2'b01, 3, 0);     // 14,15,0,1 wrap, OKAY
    run_burst(4'd5, 32'h08, 2, 2'b00, 2, 0);     // FIXED -> INCR writes, SLVERR
    run_burst(4'd6, 32'h20, 2, 2'b01, 999, 0);   // wlast missing -> SLVERR, 3 beats
    run_burst(4'd7, 32'h38, 0, 2'b01, 0, 1);     // single beat
    run_burst(4'd8, 32'h50, 255, 2'b01, 255, 0); // 256 beats

    // Reset after beat 2 of 8: two writes committed, no B, no IbWrDone
    aw_phase(4'd9, 32'h28, 7, 2'b01, 0);
    w_beat(5, 1'b0);
    w_beat(6, 1'b0);
    IbBufBusy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midburst_rst");
    rst = 1'b0;
    @(posedge clk); #1;
    run_burst(4'd10, 32'h10, 3, 2'b01, 3, 0);

    // Randomized bursts
    for (int n = 0; n < 40; n++) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0:       wl = int'($urandom_range(0, len));
        1:       wl = 999;
        default: wl = len;
      endcase
      bt = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      run_burst(4'($urandom), $urandom, len, bt, wl, ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("exp_w_drained", 128'(exp_w_q.size()), 128'(0));
    chk("exp_b_drained", 128'(exp_b_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
